// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request FIFO and issue/response sequencer for the 8-bit ALU
//
// Purpose:
//   Accepts {ctrl, x, y} operation requests over a valid/ready handshake and
//   queues them in a DEPTH-entry FIFO. Issues one operation at a time on
//   registered ALU operand/opcode ports, captures the combinational ALU
//   response one cycle later, and holds it on a valid/ready result port.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_ctrl/x/y          request opcode and operands
//   alu_ctrl/x/y          registered opcode/operands driven to the ALU
//   alu_out, alu_carry    combinational ALU response
//   res_valid/res_ready   result handshake
//   res_out/carry/err     captured result, carry, illegal-opcode flag
//   busy                  FIFO non-empty or sequencer not idle
//   op_count              completed results, modulo 256

module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_ctrl,
  input  logic [7:0] req_x,
  input  logic [7:0] req_y,
  output logic [3:0] alu_ctrl,
  output logic [7:0] alu_x,
  output logic [7:0] alu_y,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_out,
  output logic       res_carry,
  output logic       res_err,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [3:0] LAST_LEGAL_OP = 4'd12;  // EQ; 13..15 are illegal

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // FIFO storage: {ctrl, x, y}
  logic [19:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [19:0]   head;

  logic [3:0] alu_ctrl_q, alu_ctrl_d;
  logic [7:0] alu_x_q, alu_x_d;
  logic [7:0] alu_y_q, alu_y_d;
  logic       res_valid_q, res_valid_d;
  logic [7:0] res_out_q, res_out_d;
  logic       res_carry_q, res_carry_d;
  logic       res_err_q, res_err_d;
  logic [7:0] op_count_q, op_count_d;

  logic push, pop, capture, done, fifo_empty, illegal;

  // Readiness uses the registered count only, so a full FIFO refuses a push
  // even if a pop happens on the same edge.
  assign req_ready  = (count_q < DEPTH_C);
  assign push       = req_valid && req_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign illegal    = (alu_ctrl_q > LAST_LEGAL_OP);

  // FSM next state and control strobes
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // alu_* has been stable for a full cycle; sample the response now.
        capture = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          done = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Datapath next state: ALU operand registers hold their last values
  // between issues; result registers hold until the next capture.
  always_comb begin
    alu_ctrl_d  = alu_ctrl_q;
    alu_x_d     = alu_x_q;
    alu_y_d     = alu_y_q;
    res_out_d   = res_out_q;
    res_carry_d = res_carry_q;
    res_err_d   = res_err_q;
    op_count_d  = op_count_q;
    res_valid_d = (state_d == S_RESP);

    if (pop) begin
      alu_ctrl_d = head[19:16];
      alu_x_d    = head[15:8];
      alu_y_d    = head[7:0];
    end

    if (capture) begin
      if (illegal) begin
        res_out_d   = 8'h00;
        res_carry_d = 1'b0;
        res_err_d   = 1'b1;
      end else begin
        res_out_d   = alu_out;
        res_carry_d = alu_carry;
        res_err_d   = 1'b0;
      end
    end

    if (done) op_count_d = op_count_q + 8'd1;
  end

  // Storage array is not reset: entries are only read after being written,
  // and reset empties the FIFO through the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_ctrl, req_x, req_y};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_ctrl_q  <= 4'h0;
      alu_x_q     <= 8'h00;
      alu_y_q     <= 8'h00;
      res_valid_q <= 1'b0;
      res_out_q   <= 8'h00;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
      op_count_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      res_valid_q <= res_valid_d;
      res_out_q   <= res_out_d;
      res_carry_q <= res_carry_d;
      res_err_q   <= res_err_d;
      op_count_q  <= op_count_d;
    end
  end

  assign busy      = !fifo_empty || (state_q != S_IDLE);
  assign alu_ctrl  = alu_ctrl_q;
  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign res_valid = res_valid_q;
  assign res_out   = res_out_q;
  assign res_carry = res_carry_q;
  assign res_err   = res_err_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
//
// Purpose:
//   Drives directed request vectors through the sequencer with a behavioural
//   ALU attached, and compares results against hand-computed constants.

module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_ctrl;
  logic [7:0] req_x;
  logic [7:0] req_y;
  logic [3:0] alu_ctrl;
  logic [7:0] alu_x;
  logic [7:0] alu_y;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_out;
  logic       res_carry;
  logic       res_err;
  logic       busy;
  logic [7:0] op_count;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctrl  (req_ctrl),
    .req_x     (req_x),
    .req_y     (req_y),
    .alu_ctrl  (alu_ctrl),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_out   (res_out),
    .res_carry (res_carry),
    .res_err   (res_err),
    .busy      (busy),
    .op_count  (op_count)
  );

  // Behavioural ALU: shifts/rotates by one, carry is the bit shifted out
  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    case (alu_ctrl)
      4'd0:  {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
      4'd1:  {alu_carry, alu_out} = {1'b0, alu_x} - {1'b0, alu_y};
      4'd2:  alu_out = alu_x & alu_y;
      4'd3:  alu_out = alu_x | alu_y;
      4'd4:  alu_out = ~alu_x;
      4'd5:  alu_out = alu_x ^ alu_y;
      4'd6:  alu_out = ~(alu_x | alu_y);
      4'd7:  begin alu_out = {alu_x[6:0], 1'b0};     alu_carry = alu_x[7]; end
      4'd8:  begin alu_out = {1'b0, alu_x[7:1]};     alu_carry = alu_x[0]; end
      4'd9:  begin alu_out = {alu_x[7], alu_x[7:1]}; alu_carry = alu_x[0]; end
      4'd10: alu_out = {alu_x[6:0], alu_x[7]};
      4'd11: alu_out = {alu_x[0], alu_x[7:1]};
      4'd12: alu_out = {7'd0, alu_x == alu_y};
      default: begin alu_out = 8'hEE; alu_carry = 1'b1; end
    endcase
  end

  typedef struct {
    logic [3:0] ctrl;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] out;
    logic       carry;
    logic       err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
    req_valid = v;
    req_ctrl  = c;
    req_x     = x;
    req_y     = y;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{4'h0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};  // ADD with carry
    vecs[1]  = '{4'hE, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b1};  // illegal
    vecs[2]  = '{4'h1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0};  // SUB
    vecs[3]  = '{4'h1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};  // SUB borrow
    vecs[4]  = '{4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};  // AND
    vecs[5]  = '{4'h3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};  // OR
    vecs[6]  = '{4'h4, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0};  // NOT
    vecs[7]  = '{4'h5, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};  // XOR
    vecs[8]  = '{4'h6, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0};  // NOR
    vecs[9]  = '{4'h7, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0};  // SLL
    vecs[10] = '{4'h8, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0};  // SRL
    vecs[11] = '{4'h9, 8'h81, 8'h00, 8'hC0, 1'b1, 1'b0};  // SRA
    vecs[12] = '{4'hA, 8'h81, 8'h00, 8'h03, 1'b0, 1'b0};  // RL
    vecs[13] = '{4'hB, 8'h81, 8'h00, 8'hC0, 1'b0, 1'b0};  // RR
    vecs[14] = '{4'hD, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1};  // lowest illegal

    rst_n     = 1'b0;
    res_ready = 1'b1;
    drive_req(1'b0, 4'h0, 8'h00, 8'h00);
    #12;

    // Reset values
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_alu", {12'd0, alu_ctrl, alu_x, alu_y}, 32'd0);
    chk("rst_res", {22'd0, res_out, res_carry, res_err}, 32'd0);
    chk("rst_busy_ready", {30'd0, busy, req_ready}, 32'd1);
    chk("rst_op_count", {24'd0, op_count}, 32'd0);
    rst_n = 1'b1;
    step();

    // Table: single op each, exact latency, res_ready high
    for (int i = 0; i < 15; i++) begin
      drive_req(1'b1, vecs[i].ctrl, vecs[i].x, vecs[i].y);
      chk($sformatf("v%0d_req_ready", i), {31'd0, req_ready}, 32'd1);
      step();  // push edge N
      drive_req(1'b0, 4'h0, 8'h00, 8'h00);
      step();  // N+1: issue
      chk($sformatf("v%0d_alu", i), {12'd0, alu_ctrl, alu_x, alu_y},
          {12'd0, vecs[i].ctrl, vecs[i].x, vecs[i].y});
      chk($sformatf("v%0d_early_valid", i), {31'd0, res_valid}, 32'd0);
      step();  // N+2: capture
      chk($sformatf("v%0d_res", i), {21'd0, res_valid, res_out, res_carry, res_err},
          {21'd0, 1'b1, vecs[i].out, vecs[i].carry, vecs[i].err});
      chk($sformatf("v%0d_cnt_pre", i), {24'd0, op_count}, {24'd0, exp_cnt});
      step();  // N+3: handshake
      exp_cnt = exp_cnt + 8'd1;
      chk($sformatf("v%0d_cnt_post", i), {24'd0, op_count}, {24'd0, exp_cnt});
      chk($sformatf("v%0d_done", i), {30'd0, res_valid, busy}, 32'd0);
      chk($sformatf("v%0d_alu_hold", i), {24'd0, alu_x}, {24'd0, vecs[i].x});
    end

    // Full FIFO under back-pressure: 6 offered, 5 accepted
    begin
      int acc = 0;
      res_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
        drive_req(1'b1, 4'h0, 8'(8'h10 + i), 8'h01);
        if (req_ready) acc++;
        step();
      end
      drive_req(1'b0, 4'h0, 8'h00, 8'h00);
      chk("full_accepted", acc, 32'd5);
      chk("full_req_ready", {31'd0, req_ready}, 32'd0);
      step();
      chk("full_still_blocked", {30'd0, req_ready, res_valid}, 32'd1);
      res_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("full_res%0d", k), {23'd0, res_valid, res_out}, {23'd0, 1'b1, 8'(8'h11 + k)});
        step();
        exp_cnt = exp_cnt + 8'd1;
        if (k < 4) begin
          chk($sformatf("full_gap%0d", k), {31'd0, res_valid}, 32'd0);
          step();
        end
      end
      chk("full_drained", {30'd0, res_valid, busy}, 32'd0);
      chk("full_cnt", {24'd0, op_count}, {24'd0, exp_cnt});
    end

    // Back-pressure hold for 10 cycles
    res_ready = 1'b0;
    drive_req(1'b1, 4'h5, 8'h5A, 8'hFF);
    step();
    drive_req(1'b0, 4'h0, 8'h00, 8'h00);
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("hold%0d_res", c), {21'd0, res_valid, res_out, res_carry, res_err},
          {21'd0, 1'b1, 8'hA5, 1'b0, 1'b0});
      chk($sformatf("hold%0d_alu_cnt", c), {4'd0, alu_ctrl, alu_x, alu_y, op_count},
          {4'd0, 4'h5, 8'h5A, 8'hFF, exp_cnt});
      step();
    end
    res_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 8'd1;
    chk("hold_release", {23'd0, res_valid, op_count}, {23'd0, 1'b0, exp_cnt});

    // op_count wrap: reset to zero, then 257 streamed EQ ops
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    step();
    chk("wrap_start", {24'd0, op_count}, 32'd0);
    begin
      int pushed = 0;
      int done_n = 0;
      int bad = 0;
      int cyc = 0;
      while (done_n < 257 && cyc < 2000) begin
        drive_req(pushed < 257, 4'hC, 8'h3C, 8'h3C);
        if (req_valid && req_ready) pushed++;
        if (res_valid && res_ready) begin
          done_n++;
          if (res_out !== 8'h01 || res_err !== 1'b0) bad++;
        end
        step();
        cyc++;
        if (done_n == 255) chk("wrap_255", {24'd0, op_count}, 32'd255);
        if (done_n == 256 && res_valid == 1'b0) chk("wrap_0", {24'd0, op_count}, 32'd0);
        if (done_n == 257) chk("wrap_1", {24'd0, op_count}, 32'd1);
      end
      drive_req(1'b0, 4'h0, 8'h00, 8'h00);
      chk("wrap_done", done_n, 32'd257);
      chk("wrap_results", bad, 32'd0);
    end
    step();
    step();

    // Async reset while in ISSUE with requests queued
    drive_req(1'b1, 4'h0, 8'h01, 8'h01);
    step();
    drive_req(1'b1, 4'h0, 8'h02, 8'h02);
    step();
    drive_req(1'b1, 4'h0, 8'h03, 8'h03);
    step();
    drive_req(1'b0, 4'h0, 8'h00, 8'h00);
    step();  // second op issued, third queued
    chk("ar_pre_busy", {30'd0, busy, res_valid}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_outputs", {4'd0, alu_ctrl, alu_x, alu_y, op_count}, 32'd0);
    chk("ar_res", {21'd0, res_valid, res_out, res_carry, res_err}, 32'd0);
    chk("ar_busy_ready", {30'd0, busy, req_ready}, 32'd1);
    step();
    #3;
    rst_n = 1'b1;
    begin
      int stale = 0;
      for (int c = 0; c < 6; c++) begin
        step();
        if (res_valid !== 1'b0 || busy !== 1'b0) stale++;
      end
      chk("ar_no_stale", stale, 32'd0);
    end
    drive_req(1'b1, 4'h0, 8'h01, 8'h02);
    step();
    drive_req(1'b0, 4'h0, 8'h00, 8'h00);
    step();
    step();
    chk("ar_new_res", {21'd0, res_valid, res_out, res_carry, res_err},
        {21'd0, 1'b1, 8'h03, 1'b0, 1'b0});
    step();
    chk("ar_new_cnt", {24'd0, op_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
